// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings (also used by the D-stage decoder)
// and the architectural reset PC.
package cpu_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'b00,
      NPC_BR  = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_op_e;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;

endpackage

// File: rtl/npc.sv
// Next-PC selection for the F stage. Purely combinational.
// Branch and jump targets are built from the D-stage instruction, not from the current PC,
// which gives delayed-branch behaviour: the instruction in F is the delay slot.
module npc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  npc_op,
   input  logic        br_taken,
   input  logic [31:0] pc4_D,
   input  logic [15:0] imm16_D,
   input  logic [25:0] instr_index_D,
   input  logic [31:0] rs_val_D,
   output logic [31:0] npc_o
);

   logic [31:0] pc_plus4;
   logic [31:0] br_off;

   assign pc_plus4 = pc + 32'd4;
   assign br_off   = {{14{imm16_D[15]}}, imm16_D, 2'b00};

   // Select the next PC from the D-stage redirect request.
   always_comb begin
      npc_o = pc_plus4;
      unique case (npc_op)
         NPC_SEQ: npc_o = pc_plus4;
         NPC_BR:  npc_o = br_taken ? (pc4_D + br_off) : pc_plus4;
         NPC_J:   npc_o = {pc4_D[31:28], instr_index_D, 2'b00};
         NPC_JR:  npc_o = rs_val_D;
         default: npc_o = pc_plus4;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// F stage: owns the PC and fetch counter, drives the instruction memory address and
// hands IR/PC+4/PC+8 to the F/D register.
// Optional fetch address-error check is enabled with FETCH_ADEL_EN.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_LIMIT = 32'h0000_6FFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        F_en,
   input  logic [1:0]  npc_op,
   input  logic        br_taken,
   input  logic [31:0] pc4_D,
   input  logic [15:0] imm16_D,
   input  logic [25:0] instr_index_D,
   input  logic [31:0] rs_val_D,
   output logic [31:0] i_inst_addr,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] IR_F,
   output logic [31:0] pc4_F,
   output logic [31:0] pc8_F,
   output logic [31:0] fetch_cnt,
   output logic        fetch_adel
);

`ifdef FETCH_ADEL_EN
   localparam bit AdelEn = 1'b1;
`else
   localparam bit AdelEn = 1'b0;
`endif

   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic        addr_err;

   npc u_npc (
      .pc            (pc_q),
      .npc_op        (npc_op),
      .br_taken      (br_taken),
      .pc4_D         (pc4_D),
      .imm16_D       (imm16_D),
      .instr_index_D (instr_index_D),
      .rs_val_D      (rs_val_D),
      .npc_o         (pc_d)
   );

   assign fetch_cnt_d = fetch_cnt_q + 32'd1;

   // PC and fetch counter: reset dominates; F_en=0 holds both (redirects are not latched).
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= PC_RESET;
         fetch_cnt_q <= '0;
      end else if (F_en) begin
         pc_q        <= pc_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   // Misaligned or outside the instruction memory window.
   assign addr_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

   // Fetch outputs; a faulting fetch is replaced by a nop when the check is enabled.
   always_comb begin
      fetch_adel  = AdelEn & addr_err;
      IR_F        = fetch_adel ? 32'h0000_0000 : i_inst_rdata;
      i_inst_addr = pc_q;
      pc4_F       = pc_q + 32'd4;
      pc8_F       = pc_q + 32'd8;
      fetch_cnt   = fetch_cnt_q;
   end

endmodule
